// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared PS/2 Set-2 byte constants, event layout and decoder state encoding.
package ps2_scancode_decoder_pkg;

  localparam logic [7:0] PS2_E0         = 8'hE0;
  localparam logic [7:0] PS2_E1         = 8'hE1;
  localparam logic [7:0] PS2_F0         = 8'hF0;
  localparam logic [7:0] PS2_BAT_OK     = 8'hAA;
  localparam logic [7:0] PS2_BAT_FAIL   = 8'hFC;
  localparam logic [7:0] PS2_ACK        = 8'hFA;
  localparam logic [7:0] PS2_RESEND     = 8'hFE;
  localparam logic [7:0] PS2_ECHO       = 8'hEE;
  localparam logic [7:0] PS2_OVR0       = 8'h00;
  localparam logic [7:0] PS2_OVRF       = 8'hFF;
  localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;
  localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;
  localparam logic [7:0] PS2_LSHIFT     = 8'h12;
  localparam logic [7:0] PS2_RSHIFT     = 8'h59;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ev_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FETCH
  } state_t;

  // Keyboards wrap extended keys in shift make/break codes that carry no key meaning.
  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == PS2_LSHIFT) || (b == PS2_RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Key-event valid/ready channel from the decoder to the keyboard matrix mapper.
interface ps2_scancode_decoder_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;

  modport master (output ev_valid, ev_code, ev_ext, ev_break, input ev_ready);
  modport slave  (input ev_valid, ev_code, ev_ext, ev_break, output ev_ready);
endinterface

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO with a registered head; full pushes are dropped unless a pop frees space.
module ps2_event_fifo
  import ps2_scancode_decoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  ev_t  din,
  input  logic ready,
  output logic valid,
  output ev_t  head,
  output logic dropped
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  ev_t           mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]   count, count_nxt;
  logic          pop, push_ok, full, empty;

  always_comb begin
    pop        = valid & ready;
    full       = (count == (AW+1)'(FIFO_DEPTH));
    empty      = (count == '0);
    push_ok    = push & (~full | pop);
    rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
    count_nxt  = count;
    if (push_ok && !pop)
      count_nxt = count + 1'b1;
    else if (!push_ok && pop)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= din;
  end

  // The head register bypasses din when the entry being written becomes the new head.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid   <= 1'b0;
      head    <= '0;
      dropped <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr  <= rd_ptr_nxt;
      count   <= count_nxt;
      valid   <= (count_nxt != '0);
      head    <= (push_ok && (wr_ptr == rd_ptr_nxt)) ? din : mem[rd_ptr_nxt];
      dropped <= push & ~push_ok & ~empty;
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Pulls bytes from the PS/2 receiver, folds E0/F0/E1 prefixes into key events and queues them.
module ps2_scancode_decoder
  import ps2_scancode_decoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter bit          FILTER_FAKE_SHIFT = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    rx_q,
  input  logic                          rx_dsr,
  output logic                          rx_rden,
  input  logic                          rx_overflow,
  ps2_scancode_decoder_if.master        ev,
  output logic                          ev_dropped,
  output logic                          kbd_bat,
  output logic                          kbd_err
);

  state_t     state;
  logic       ext_pend, brk_pend;
  logic [2:0] skip;

  logic       ext_e, brk_e, ext_n, brk_n, push, err_n, bat_n;
  logic [2:0] skip_e, skip_n;
  ev_t        ev_in, head;
  logic       fifo_valid;

  // A receiver watchdog pulse wipes prefix state before the fetched byte is decoded.
  always_comb begin
    ext_e  = rx_overflow ? 1'b0 : ext_pend;
    brk_e  = rx_overflow ? 1'b0 : brk_pend;
    skip_e = rx_overflow ? 3'd0 : skip;
    ext_n  = ext_e;
    brk_n  = brk_e;
    skip_n = skip_e;
    push   = 1'b0;
    ev_in  = '0;
    err_n  = 1'b0;
    bat_n  = 1'b0;
    if (state == FETCH) begin
      if (skip_e != 3'd0) begin
        skip_n = skip_e - 3'd1;
      end else if (rx_q == PS2_E1) begin
        skip_n     = PS2_PAUSE_SKIP;
        push       = 1'b1;
        ev_in.ext  = 1'b1;
        ev_in.brk  = 1'b0;
        ev_in.code = PS2_PAUSE_CODE;
        ext_n      = 1'b0;
        brk_n      = 1'b0;
      end else if (rx_q == PS2_E0) begin
        ext_n = 1'b1;
      end else if (rx_q == PS2_F0) begin
        brk_n = 1'b1;
      end else if (rx_q inside {PS2_OVR0, PS2_OVRF, PS2_BAT_FAIL}) begin
        err_n = 1'b1;
        ext_n = 1'b0;
        brk_n = 1'b0;
      end else if ((rx_q == PS2_BAT_OK) && !ext_e && !brk_e) begin
        bat_n = 1'b1;
      end else if (rx_q inside {PS2_ACK, PS2_RESEND, PS2_ECHO}) begin
        ext_n = ext_e;
      end else begin
        push       = !(FILTER_FAKE_SHIFT && ext_e && is_fake_shift(rx_q));
        ev_in.ext  = ext_e;
        ev_in.brk  = brk_e;
        ev_in.code = rx_q;
        ext_n      = 1'b0;
        brk_n      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rx_rden  <= 1'b0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      skip     <= 3'd0;
      kbd_err  <= 1'b0;
      kbd_bat  <= 1'b0;
    end else begin
      ext_pend <= ext_n;
      brk_pend <= brk_n;
      skip     <= skip_n;
      kbd_err  <= err_n;
      kbd_bat  <= bat_n;
      rx_rden  <= 1'b0;
      case (state)
        IDLE: if (rx_dsr) begin
          state   <= REQ;
          rx_rden <= 1'b1;
        end
        REQ:     state <= FETCH;
        FETCH:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  ps2_event_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .din     (ev_in),
    .ready   (ev.ev_ready),
    .valid   (fifo_valid),
    .head    (head),
    .dropped (ev_dropped)
  );

  assign ev.ev_valid = fifo_valid;
  assign ev.ev_code  = head.code;
  assign ev.ev_ext   = head.ext;
  assign ev.ev_break = head.brk;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder with hand-computed expected events.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_q = 8'h00;
  logic       rx_dsr = 1'b0;
  logic       rx_rden;
  logic       rx_overflow = 1'b0;
  logic       ev_dropped, kbd_bat, kbd_err;

  int total = 0;
  int bad = 0;
  int bytes_sent = 0;
  int rden_cnt = 0;

  ps2_scancode_decoder_if ev_if ();

  ps2_scancode_decoder #(.FIFO_DEPTH(4), .FILTER_FAKE_SHIFT(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_q        (rx_q),
    .rx_dsr      (rx_dsr),
    .rx_rden     (rx_rden),
    .rx_overflow (rx_overflow),
    .ev          (ev_if),
    .ev_dropped  (ev_dropped),
    .kbd_bat     (kbd_bat),
    .kbd_err     (kbd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_rden) rden_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Returns on the falling edge just after the FETCH clock edge.
  task automatic send_byte(input logic [7:0] b);
    bit seen;
    seen   = 1'b0;
    rx_q   = b;
    rx_dsr = 1'b1;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clk);
      if (rx_rden) seen = 1'b1;
    end
    chk("rden_seen", seen, 1);
    rx_dsr = 1'b0;
    bytes_sent++;
    @(negedge clk);
    chk("rden_width", rx_rden, 0);
    @(negedge clk);
  endtask

  task automatic expect_ev(input string tag, input logic [7:0] c, input logic e, input logic b);
    chk({tag, "_valid"}, ev_if.ev_valid, 1);
    chk({tag, "_code"}, ev_if.ev_code, c);
    chk({tag, "_ext"}, ev_if.ev_ext, e);
    chk({tag, "_brk"}, ev_if.ev_break, b);
    ev_if.ev_ready = 1'b1;
    @(negedge clk);
    ev_if.ev_ready = 1'b0;
  endtask

  initial begin
    bit seen;
    ev_if.ev_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", ev_if.ev_valid, 0);
    chk("rst_rden", rx_rden, 0);
    chk("rst_bat", kbd_bat, 0);
    chk("rst_err", kbd_err, 0);
    chk("rst_drop", ev_dropped, 0);
    reset = 1'b0;
    @(negedge clk);

    send_byte(8'h1C);
    expect_ev("make1c", 8'h1C, 0, 0);
    send_byte(8'hF0); send_byte(8'h1C);
    expect_ev("brk1c", 8'h1C, 0, 1);
    chk("empty1", ev_if.ev_valid, 0);

    send_byte(8'hE0); send_byte(8'h75);
    expect_ev("ext75", 8'h75, 1, 0);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    expect_ev("extbrk75", 8'h75, 1, 1);
    send_byte(8'hE0); send_byte(8'h12); send_byte(8'hE0); send_byte(8'h75);
    expect_ev("fakeshift", 8'h75, 1, 0);
    chk("empty2", ev_if.ev_valid, 0);

    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    send_byte(8'h1C);
    expect_ev("pause", 8'h77, 1, 0);
    expect_ev("after_pause", 8'h1C, 0, 0);
    chk("empty3", ev_if.ev_valid, 0);

    send_byte(8'h15);
    chk("first_latency", ev_if.ev_valid, 1);
    send_byte(8'h16); send_byte(8'h17); send_byte(8'h18);
    chk("no_drop_at_4", ev_dropped, 0);
    send_byte(8'h19);
    chk("drop_pulse", ev_dropped, 1);
    @(negedge clk);
    chk("drop_one_cycle", ev_dropped, 0);
    repeat (3) @(negedge clk);
    chk("stall_code", ev_if.ev_code, 8'h15);
    expect_ev("drain15", 8'h15, 0, 0);
    expect_ev("drain16", 8'h16, 0, 0);
    expect_ev("drain17", 8'h17, 0, 0);
    expect_ev("drain18", 8'h18, 0, 0);
    chk("empty4", ev_if.ev_valid, 0);

    send_byte(8'hE0);
    rx_overflow = 1'b1;
    @(negedge clk);
    rx_overflow = 1'b0;
    send_byte(8'h1C);
    expect_ev("ovf_clears_ext", 8'h1C, 0, 0);
    send_byte(8'hFF);
    chk("err_pulse", kbd_err, 1);
    chk("err_no_event", ev_if.ev_valid, 0);
    @(negedge clk);
    chk("err_one_cycle", kbd_err, 0);
    send_byte(8'hAA);
    chk("bat_pulse", kbd_bat, 1);
    chk("bat_no_event", ev_if.ev_valid, 0);
    send_byte(8'hE0); send_byte(8'hFA); send_byte(8'h74);
    expect_ev("ack_keeps_ext", 8'h74, 1, 0);

    send_byte(8'h15); send_byte(8'h16);
    chk("queued_valid", ev_if.ev_valid, 1);
    seen   = 1'b0;
    rx_q   = 8'h1C;
    rx_dsr = 1'b1;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clk);
      if (rx_rden) seen = 1'b1;
    end
    chk("req_seen", seen, 1);
    reset  = 1'b1;
    rx_dsr = 1'b0;
    bytes_sent++;
    @(negedge clk);
    chk("rstreq_valid", ev_if.ev_valid, 0);
    chk("rstreq_rden", rx_rden, 0);
    chk("rstreq_drop", ev_dropped, 0);
    chk("rstreq_bat", kbd_bat, 0);
    chk("rstreq_err", kbd_err, 0);
    reset = 1'b0;
    @(negedge clk);
    send_byte(8'h1C);
    expect_ev("post_reset", 8'h1C, 0, 0);
    chk("empty5", ev_if.ev_valid, 0);

    chk("rden_count", rden_cnt, bytes_sent);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
